cubehash_ctrl: RTL and testbench

- Sequencer for the CubeHash-16/32-256 permutation core.
- Sits between the 16-bit host interface and the round datapath.
- On host `init` it sequences IV load plus initialisation rounds. On the interface `start` pulse it sequences message-block XOR, 16 rounds and, for the last block, the finalisation XOR plus 160 rounds.
- Reports `busy` back to the interface and `hash_valid` when the 256-bit digest is stable.

---
 rtl/cubehash_ctrl_if.sv | 23 ++
 rtl/cubehash_ctrl.sv | 122 ++++++++++++
 tb/tb_cubehash_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cubehash_ctrl_if.sv
// Host/core control bundle for the CubeHash-16/32-256 sequencer.
// The master drives requests; the slave (controller) drives status and core strobes.
interface cubehash_ctrl_if;
    logic init;
    logic start;
    logic last;
    logic busy;
    logic iv_load;
    logic msg_xor;
    logic fin_xor;
    logic round_en;
    logic hash_valid;

    modport master (
        output init, start, last,
        input  busy, iv_load, msg_xor, fin_xor, round_en, hash_valid
    );

    modport slave (
        input  init, start, last,
        output busy, iv_load, msg_xor, fin_xor, round_en, hash_valid
    );
endinterface

// File: rtl/cubehash_ctrl.sv
// Round sequencer for the CubeHash-16/32-256 core: IV load + init rounds, block
// absorption, and finalisation, with registered one-hot core strobes.
module cubehash_ctrl #(
    parameter int unsigned ROUNDS_BLK  = 16,
    parameter int unsigned ROUNDS_FIN  = 160,
    parameter int unsigned ROUNDS_INIT = 160
) (
    input  logic           clk,
    input  logic           rst_n,
    cubehash_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle, StLoad, StIround, StAbsorb, StBround, StFxor, StFround, StDone
    } state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic       inited_q;
    logic       last_q;
    logic       iv_load_q;
    logic       msg_xor_q;
    logic       fin_xor_q;
    logic       round_en_q;
    logic       hash_valid_q;
    logic       accept;

    // Strobes are set together with the next state, so each one mirrors exactly one state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            inited_q     <= 1'b0;
            last_q       <= 1'b0;
            iv_load_q    <= 1'b0;
            msg_xor_q    <= 1'b0;
            fin_xor_q    <= 1'b0;
            round_en_q   <= 1'b0;
            hash_valid_q <= 1'b0;
        end else begin
            iv_load_q  <= 1'b0;
            msg_xor_q  <= 1'b0;
            fin_xor_q  <= 1'b0;
            round_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.init) begin
                        state_q      <= StLoad;
                        iv_load_q    <= 1'b1;
                        hash_valid_q <= 1'b0;
                    end else if (bus.start && inited_q) begin
                        state_q   <= StAbsorb;
                        msg_xor_q <= 1'b1;
                        last_q    <= bus.last;
                    end
                end
                StLoad: begin
                    state_q    <= StIround;
                    cnt_q      <= 8'(ROUNDS_INIT);
                    round_en_q <= 1'b1;
                end
                StIround: begin
                    if (cnt_q == 8'd1) begin
                        state_q  <= StIdle;
                        inited_q <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_q - 8'd1;
                        round_en_q <= 1'b1;
                    end
                end
                StAbsorb: begin
                    state_q    <= StBround;
                    cnt_q      <= 8'(ROUNDS_BLK);
                    round_en_q <= 1'b1;
                end
                StBround: begin
                    if (cnt_q == 8'd1) begin
                        if (last_q) begin
                            state_q   <= StFxor;
                            fin_xor_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q      <= cnt_q - 8'd1;
                        round_en_q <= 1'b1;
                    end
                end
                StFxor: begin
                    state_q    <= StFround;
                    cnt_q      <= 8'(ROUNDS_FIN);
                    round_en_q <= 1'b1;
                end
                StFround: begin
                    if (cnt_q == 8'd1) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q      <= cnt_q - 8'd1;
                        round_en_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q      <= StIdle;
                    hash_valid_q <= 1'b1;
                    inited_q     <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Combinational accept term keeps busy high on the very cycle a request is taken.
    assign accept = (state_q == StIdle) && (bus.init || (bus.start && inited_q));

    assign bus.busy       = (state_q != StIdle) || accept;
    assign bus.iv_load    = iv_load_q;
    assign bus.msg_xor    = msg_xor_q;
    assign bus.fin_xor    = fin_xor_q;
    assign bus.round_en   = round_en_q;
    assign bus.hash_valid = hash_valid_q;

endmodule

// File: tb/tb_cubehash_ctrl.sv
// Scoreboard bench for cubehash_ctrl: the driver queues expected core strobes per
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_cubehash_ctrl;

    localparam logic [3:0] CtlIv  = 4'b1000;
    localparam logic [3:0] CtlMsg = 4'b0100;
    localparam logic [3:0] CtlFin = 4'b0010;
    localparam logic [3:0] CtlRnd = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] ctl;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    cubehash_ctrl_if bus ();

    cubehash_ctrl #(
        .ROUNDS_BLK (16),
        .ROUNDS_FIN (160),
        .ROUNDS_INIT(160)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: any active strobe must match the head of the scoreboard at its cycle.
    logic [3:0] mon_ctl;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_e = sb.pop_front();
                check("missing_ctl", 32'(mon_e.cyc), 32'hffff_ffff);
            end
            mon_ctl = {bus.iv_load, bus.msg_xor, bus.fin_xor, bus.round_en};
            if (mon_ctl != 4'b0000) begin
                if (sb.size() == 0) begin
                    check("unexpected_ctl", 32'(mon_ctl), 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ctl_kind", 32'(mon_ctl), 32'(mon_e.ctl));
                    check("ctl_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
    end

    task automatic push_init(input int t);
        sb.push_back('{t + 1, CtlIv});
        for (int i = 2; i <= 161; i++) sb.push_back('{t + i, CtlRnd});
    endtask

    task automatic push_blk(input int t, input logic last);
        sb.push_back('{t + 1, CtlMsg});
        for (int i = 2; i <= 17; i++) sb.push_back('{t + i, CtlRnd});
        if (last) begin
            sb.push_back('{t + 18, CtlFin});
            for (int i = 19; i <= 178; i++) sb.push_back('{t + i, CtlRnd});
        end
    endtask

    task automatic drive(input logic i, input logic s, input logic l, input logic busy_exp,
                         output int t);
        @(negedge clk);
        bus.init  = i;
        bus.start = s;
        bus.last  = l;
        t = cyc;
        #1;
        check("busy_on_request", 32'(bus.busy), 32'(busy_exp));
    endtask

    task automatic clear_inputs();
        @(negedge clk);
        bus.init  = 1'b0;
        bus.start = 1'b0;
        bus.last  = 1'b0;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic logic [5:0] all_outs();
        return {bus.busy, bus.iv_load, bus.msg_xor, bus.fin_xor, bus.round_en, bus.hash_valid};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        cyc       = 0;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.init  = 1'b0;
        bus.start = 1'b0;
        bus.last  = 1'b0;
        #3;
        check("reset_outputs", 32'(all_outs()), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // start before any init is ignored
        drive(1'b0, 1'b1, 1'b0, 1'b0, t);
        clear_inputs();
        repeat (5) @(negedge clk);
        check("start_uninit_busy", 32'(bus.busy), 32'h0);

        // init sequence
        drive(1'b1, 1'b0, 1'b0, 1'b1, t);
        push_init(t);
        clear_inputs();
        at_cycle(t + 161);
        check("init_busy_last_round", 32'(bus.busy), 32'h1);
        at_cycle(t + 162);
        check("init_busy_low", 32'(bus.busy), 32'h0);
        check("init_hash_valid", 32'(bus.hash_valid), 32'h0);

        // non-final block
        drive(1'b0, 1'b1, 1'b0, 1'b1, t);
        push_blk(t, 1'b0);
        clear_inputs();
        at_cycle(t + 17);
        check("blk_busy_last_round", 32'(bus.busy), 32'h1);
        at_cycle(t + 18);
        check("blk_busy_low", 32'(bus.busy), 32'h0);
        check("blk_hash_valid", 32'(bus.hash_valid), 32'h0);

        // requests during BROUND are dropped
        drive(1'b0, 1'b1, 1'b0, 1'b1, t);
        push_blk(t, 1'b0);
        clear_inputs();
        at_cycle(t + 5);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        at_cycle(t + 8);
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        at_cycle(t + 18);
        check("collide_busy_low", 32'(bus.busy), 32'h0);

        // final block
        drive(1'b0, 1'b1, 1'b1, 1'b1, t);
        push_blk(t, 1'b1);
        clear_inputs();
        at_cycle(t + 179);
        check("fin_done_busy", 32'(bus.busy), 32'h1);
        check("fin_hv_before", 32'(bus.hash_valid), 32'h0);
        at_cycle(t + 180);
        check("fin_hv_set", 32'(bus.hash_valid), 32'h1);
        check("fin_busy_low", 32'(bus.busy), 32'h0);
        repeat (5) @(negedge clk);
        check("fin_hv_held", 32'(bus.hash_valid), 32'h1);

        // start after finalisation is ignored until init
        drive(1'b0, 1'b1, 1'b0, 1'b0, t);
        clear_inputs();
        repeat (4) @(negedge clk);
        check("post_fin_hv", 32'(bus.hash_valid), 32'h1);

        // init and start together: init wins, hash_valid cleared on iv_load cycle
        drive(1'b1, 1'b1, 1'b1, 1'b1, t);
        push_init(t);
        clear_inputs();
        check("init_clears_hv", 32'(bus.hash_valid), 32'h0);
        at_cycle(t + 162);
        check("collide_init_busy_low", 32'(bus.busy), 32'h0);

        // asynchronous reset in the middle of FROUND
        drive(1'b0, 1'b1, 1'b1, 1'b1, t);
        push_blk(t, 1'b1);
        clear_inputs();
        at_cycle(t + 68);
        #1;
        check("fround_round_en", 32'(bus.round_en), 32'h1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midop_reset_outputs", 32'(all_outs()), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, t);
        clear_inputs();
        repeat (5) @(negedge clk);
        check("post_reset_busy", 32'(bus.busy), 32'h0);

        // fresh init after reset works again
        drive(1'b1, 1'b0, 1'b0, 1'b1, t);
        push_init(t);
        clear_inputs();
        at_cycle(t + 162);
        check("reinit_busy_low", 32'(bus.busy), 32'h0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
